// File: rtl/stopwatch_ctrl.sv
// Run/lap/clear controller for an mm:ss stopwatch: owns the 1 s prescaler and the BCD count,
// and presents registered run/lap flags, display digits and a rollover pulse.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_p,
  input  logic        lap_p,
  output logic        run,
  output logic        lap_active,
  output logic [15:0] digits,
  output logic        wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [15:0]   count, count_nxt;
  logic [15:0]   lap_reg, lap_nxt;
  logic [15:0]   digits_nxt;
  logic          counting, tick;
  logic          run_nxt, lap_active_nxt, wrap_nxt;

  function automatic logic [15:0] bcd_inc(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    if (c[3:0] != 4'd9) begin
      r[3:0] = c[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (c[7:4] != 4'd5) begin
        r[7:4] = c[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (c[11:8] != 4'd9) begin
          r[11:8] = c[11:8] + 4'd1;
        end else begin
          r[11:8] = 4'd0;
          r[15:12] = (c[15:12] != 4'd5) ? c[15:12] + 4'd1 : 4'd0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // start_p has priority over lap_p in every state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_p) state_nxt = RUN;
      RUN:     if (start_p) state_nxt = PAUSE; else if (lap_p) state_nxt = LAP;
      LAP:     if (start_p) state_nxt = PAUSE; else if (lap_p) state_nxt = RUN;
      PAUSE:   if (start_p) state_nxt = RUN;   else if (lap_p) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign counting = (state == RUN) || (state == LAP);
  assign tick     = counting && (presc == TERM);

  // Datapath follows the current state, so a tick on the edge that leaves RUN still lands.
  always_comb begin
    presc_nxt = presc;
    if (tick) begin
      presc_nxt = '0;
    end else if (counting) begin
      presc_nxt = presc + ONE;
    end else if (state_nxt == IDLE) begin
      presc_nxt = '0;
    end

    count_nxt = count;
    if (state == PAUSE && state_nxt == IDLE) begin
      count_nxt = '0;
    end else if (tick) begin
      count_nxt = bcd_inc(count);
    end

    lap_nxt  = (state == RUN && state_nxt == LAP) ? count_nxt : lap_reg;
    wrap_nxt = tick && (count == 16'h5959);
  end

  always_comb begin
    run_nxt        = (state_nxt == RUN) || (state_nxt == LAP);
    lap_active_nxt = (state_nxt == LAP);
    digits_nxt     = lap_active_nxt ? lap_nxt : count_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      count      <= '0;
      lap_reg    <= '0;
      run        <= 1'b0;
      lap_active <= 1'b0;
      digits     <= '0;
      wrap       <= 1'b0;
    end else begin
      presc      <= presc_nxt;
      count      <= count_nxt;
      lap_reg    <= lap_nxt;
      run        <= run_nxt;
      lap_active <= lap_active_nxt;
      digits     <= digits_nxt;
      wrap       <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: TICK_DIV=4 instance for control flow, TICK_DIV=2 for rollover.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_p, lap_p, run, lap_active, wrap;
  logic [15:0] digits;
  logic        rst_w, start_w, lap_w, run_w, lap_active_w, wrap_w;
  logic [15:0] digits_w;

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start_p(start_p), .lap_p(lap_p),
    .run(run), .lap_active(lap_active), .digits(digits), .wrap(wrap)
  );

  stopwatch_ctrl #(.TICK_DIV(2)) dut_w (
    .clk(clk), .rst(rst_w), .start_p(start_w), .lap_p(lap_w),
    .run(run_w), .lap_active(lap_active_w), .digits(digits_w), .wrap(wrap_w)
  );

  typedef struct {
    string       tag;
    logic        on_w;
    logic [18:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string tag, input logic on_w, input logic r, input logic l,
                      input logic w, input logic [15:0] d);
    exp_t e;
    e.tag  = tag;
    e.on_w = on_w;
    e.exp  = {r, l, w, d};
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t        e;
    logic [18:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = e.on_w ? {run_w, lap_active_w, wrap_w, digits_w} : {run, lap_active, wrap, digits};
      tests++;
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s: observed run/lap/wrap/digits=%b/%b/%b/%h expected %b/%b/%b/%h",
               e.tag, obs[18], obs[17], obs[16], obs[15:0],
               e.exp[18], e.exp[17], e.exp[16], e.exp[15:0]);
      end
    end
  endtask

  task automatic chk(input string tag, input logic r, input logic l, input logic w,
                     input logic [15:0] d);
    push(tag, 1'b0, r, l, w, d);
    compare();
  endtask

  task automatic pulse(input logic s, input logic l);
    start_p = s;
    lap_p   = l;
    step(1);
    start_p = 1'b0;
    lap_p   = 1'b0;
  endtask

  // Asynchronous reset between edges, released on the following falling edge.
  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start_p = 1'b0; lap_p = 1'b0;
    rst_w = 1'b1; start_w = 1'b0; lap_w = 1'b0;
    step(2);
    chk("reset_hold", 0, 0, 0, 16'h0000);
    rst = 1'b0; rst_w = 1'b0;
    step(1);
    chk("reset_idle", 0, 0, 0, 16'h0000);

    // Start and count: first tick TICK_DIV edges after entering RUN.
    push("start_run", 1'b0, 1, 0, 0, 16'h0000);
    pulse(1, 0);
    compare();
    step(3);  chk("pre_first_tick", 1, 0, 0, 16'h0000);
    step(1);  chk("first_tick", 1, 0, 0, 16'h0001);
    step(35); chk("count_0009", 1, 0, 0, 16'h0009);
    step(1);  chk("count_0010", 1, 0, 0, 16'h0010);

    #1 rst = 1'b1;
    #1 chk("async_rst_run", 0, 0, 0, 16'h0000);
    step(1);
    rst = 1'b0;

    // Lap freeze and release while the live count keeps going.
    pulse(1, 0);
    step(20); chk("run_0005", 1, 0, 0, 16'h0005);
    pulse(0, 1); chk("lap_freeze", 1, 1, 0, 16'h0005);
    step(11);    chk("lap_held", 1, 1, 0, 16'h0005);
    pulse(0, 1); chk("lap_release", 1, 0, 0, 16'h0008);

    // Pause keeps the prescaler phase; resume finishes the remaining count.
    async_reset();
    pulse(1, 0);
    step(28);    chk("run_0007", 1, 0, 0, 16'h0007);
    pulse(1, 0); chk("pause", 0, 0, 0, 16'h0007);
    step(20);    chk("pause_hold", 0, 0, 0, 16'h0007);
    pulse(1, 0); chk("resume", 1, 0, 0, 16'h0007);
    step(2);     chk("resume_phase", 1, 0, 0, 16'h0007);
    step(1);     chk("resume_tick", 1, 0, 0, 16'h0008);

    // Pause then clear; a second lap in IDLE does nothing; prescaler restarts from 0.
    pulse(1, 0); chk("pause_again", 0, 0, 0, 16'h0008);
    pulse(0, 1); chk("clear", 0, 0, 0, 16'h0000);
    pulse(0, 1); chk("idle_lap_ignored", 0, 0, 0, 16'h0000);
    pulse(1, 0); chk("restart", 1, 0, 0, 16'h0000);
    step(3);     chk("restart_pre_tick", 1, 0, 0, 16'h0000);
    step(1);     chk("restart_tick", 1, 0, 0, 16'h0001);

    // start_p and lap_p together in RUN: start wins, no lap capture.
    pulse(1, 1); chk("collide", 0, 0, 0, 16'h0001);
    step(8);     chk("collide_paused", 0, 0, 0, 16'h0001);
    pulse(0, 1); chk("collide_then_clear", 0, 0, 0, 16'h0000);

    // Stop sampled on the terminal prescaler cycle still counts the tick.
    async_reset();
    pulse(1, 0);
    step(3);
    pulse(1, 0); chk("stop_on_tick", 0, 0, 0, 16'h0001);
    step(10);    chk("stop_on_tick_hold", 0, 0, 0, 16'h0001);

    // Reset in the middle of LAP.
    async_reset();
    pulse(1, 0);
    step(8);
    pulse(0, 1); chk("lap_0002", 1, 1, 0, 16'h0002);
    step(3);
    #1 rst = 1'b1;
    #1 chk("rst_mid_lap", 0, 0, 0, 16'h0000);
    step(1);
    rst = 1'b0;

    // Rollover on the TICK_DIV=2 instance.
    start_w = 1'b1;
    step(1);
    start_w = 1'b0;
    push("w_5959", 1'b1, 1, 0, 0, 16'h5959);
    step(7198); compare();
    push("w_5959_hold", 1'b1, 1, 0, 0, 16'h5959);
    step(1);    compare();
    push("w_wrap", 1'b1, 1, 0, 1, 16'h0000);
    step(1);    compare();
    push("w_wrap_one_cycle", 1'b1, 1, 0, 0, 16'h0000);
    step(1);    compare();
    push("w_after_wrap", 1'b1, 1, 0, 0, 16'h0001);
    step(1);    compare();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
